// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode bit positions and select-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  localparam int unsigned MODE_CPOL = 1;
  localparam int unsigned MODE_CPHA = 0;

  // Width of a select index for nsel lines; a single line still needs one bit.
  function automatic int unsigned sel_width(input int unsigned nsel);
    return (nsel > 1) ? int'($clog2(nsel)) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter; tick_c flags the terminal count and the counter reloads on it.
module spi_clk_div #(
  parameter int unsigned DIVW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [DIVW-1:0] load_val,
  output logic            tick_c
);

  logic [DIVW-1:0] cnt_q;

  assign tick_c = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load || tick_c) begin
      cnt_q <= load_val;
    end else begin
      cnt_q <= cnt_q - DIVW'(1);
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI master: one WIDTH-bit frame per accepted start, all four CPOL/CPHA modes,
// MSB/LSB-first order, runtime SCLK divider and NSEL active-low selects.
module spi_master_xfer
  import spi_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NSEL  = 1,
  parameter  int unsigned DIVW  = 8,
  localparam int unsigned SELW  = sel_width(NSEL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             lsb_first,
  input  logic [DIVW-1:0]  div,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] mdat,
  output logic [WIDTH-1:0] sdat,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [NSEL-1:0]  ss_n
);

  localparam int unsigned EDGES = 2 * WIDTH;
  localparam int unsigned EW    = $clog2(EDGES);

  spi_state_e       state_q, state_d;
  logic [1:0]       mode_q;
  logic             lsb_q;
  logic [DIVW-1:0]  div_q;
  logic [EW-1:0]    edge_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;

  logic             accept_c;
  logic             tick_c;
  logic             xtick_c;
  logic             last_edge_c;
  logic             lead_c;
  logic             smp_c;
  logic             adv_c;
  logic [DIVW-1:0]  load_val_c;

  function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

  assign accept_c    = start && (state_q == ST_IDLE);
  assign load_val_c  = accept_c ? div : div_q;
  assign xtick_c     = (state_q == ST_XFER) && tick_c;
  assign last_edge_c = (edge_q == EW'(EDGES - 1));
  // edge_q counts XFER ticks from 0; ticks with even edge_q move sclk away from CPOL.
  assign lead_c      = ~edge_q[0];
  assign smp_c       = xtick_c && (lead_c != mode_q[MODE_CPHA]);
  assign adv_c       = xtick_c && (mode_q[MODE_CPHA] ? lead_c : (!lead_c && !last_edge_c));

  spi_clk_div #(
    .DIVW (DIVW)
  ) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .load     (accept_c),
    .load_val (load_val_c),
    .tick_c   (tick_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every phase except IDLE lasts whole half-periods.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)                  state_d = ST_LEAD;
      ST_LEAD:  if (tick_c)                 state_d = ST_XFER;
      ST_XFER:  if (tick_c && last_edge_c)  state_d = ST_TRAIL;
      ST_TRAIL: if (tick_c)                 state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Latched frame options, shifters and registered pin/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      lsb_q  <= 1'b0;
      div_q  <= '0;
      edge_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      sdat   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sclk   <= 1'b0;
      mosi   <= 1'b0;
      ss_n   <= '1;
    end else begin
      done <= 1'b0;

      if (accept_c) begin
        mode_q <= mode;
        lsb_q  <= lsb_first;
        div_q  <= div;
        edge_q <= '0;
        busy   <= 1'b1;
        sclk   <= mode[MODE_CPOL];
        for (int unsigned i = 0; i < NSEL; i++) begin
          ss_n[i] <= (SELW'(i) != sel);
        end
        // CPHA=0 presents the first bit before the first edge.
        if (!mode[MODE_CPHA]) begin
          mosi <= first_bit(mdat, lsb_first);
          tx_q <= shift_out(mdat, lsb_first);
        end else begin
          tx_q <= mdat;
        end
      end

      if (xtick_c) begin
        sclk   <= ~sclk;
        edge_q <= edge_q + EW'(1);
      end

      if (adv_c) begin
        mosi <= first_bit(tx_q, lsb_q);
        tx_q <= shift_out(tx_q, lsb_q);
      end

      if (smp_c) begin
        rx_q <= lsb_q ? {miso, rx_q[WIDTH-1:1]} : {rx_q[WIDTH-2:0], miso};
      end

      if ((state_q == ST_TRAIL) && tick_c) begin
        ss_n <= '1;
        busy <= 1'b0;
        done <= 1'b1;
        sdat <= rx_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Self-checking bench for spi_master_xfer: protocol-level slave model on the pins plus timing checks.
module tb_spi_master_xfer;

  localparam int unsigned W    = 8;
  localparam int unsigned NSEL = 5;
  localparam int unsigned DIVW = 8;
  localparam int unsigned SELW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = '0;
  logic            lsb_first = 1'b0;
  logic [DIVW-1:0] div = '0;
  logic [SELW-1:0] sel = '0;
  logic [W-1:0]    mdat = '0;
  logic [W-1:0]    sdat;
  logic            busy, done, sclk, mosi, miso;
  logic [NSEL-1:0] ss_n;

  int checks = 0;
  int failures = 0;

  // Slave/monitor state
  logic            m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic [W-1:0]    slv_tx = '0, slv_rx = '0;
  logic            slv_miso = 1'b0, loop_en = 1'b0;
  logic [NSEL-1:0] m_ss_exp = '1;
  logic            mon_busy = 1'b0, prev_sclk = 1'b0, leading;
  int              mon_edges = 0, mon_in = 0, mon_out = 0, mon_cyc = 0, mon_last = 0;
  int              gap_min = 1000, gap_max = 0, mon_ss_err = 0;
  logic            slv_bits[$];

  // Per-frame results
  int              r_done;
  logic [NSEL-1:0] r_ss1;
  logic            r_sclk1, r_busy1, r_busy_poke;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : slv_miso;

  spi_master_xfer #(
    .WIDTH (W),
    .NSEL  (NSEL),
    .DIVW  (DIVW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .lsb_first (lsb_first),
    .div       (div),
    .sel       (sel),
    .mdat      (mdat),
    .sdat      (sdat),
    .busy      (busy),
    .done      (done),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss_n      (ss_n)
  );

  function automatic logic wbit(input logic [W-1:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[W-1-i];
  endfunction

  function automatic logic [NSEL-1:0] ss_exp(input logic [SELW-1:0] s);
    logic [NSEL-1:0] r;
    r = '1;
    if (32'(s) < NSEL) r[s] = 1'b0;
    return r;
  endfunction

  function automatic int done_at(input logic [DIVW-1:0] dv);
    return 1 + (2 * W + 2) * (int'(dv) + 1);
  endfunction

  // SPI slave seen from the pins: edges classified against CPOL, acting per CPHA.
  always @(negedge clk) begin
    mon_cyc++;
    if (busy && !mon_busy) begin
      mon_edges = 0; mon_in = 0; mon_out = 0; slv_rx = '0; slv_bits.delete();
      prev_sclk = sclk; mon_last = mon_cyc; gap_min = 1000; gap_max = 0;
      if (!m_cpha) begin
        slv_miso = wbit(slv_tx, 0, m_lsb);
        mon_out = 1;
      end
    end else if (busy && (sclk !== prev_sclk)) begin
      mon_edges++;
      leading = (prev_sclk == m_cpol);
      prev_sclk = sclk;
      if (mon_edges > 1) begin
        if (mon_cyc - mon_last < gap_min) gap_min = mon_cyc - mon_last;
        if (mon_cyc - mon_last > gap_max) gap_max = mon_cyc - mon_last;
      end
      mon_last = mon_cyc;
      if (leading != m_cpha) begin
        slv_bits.push_back(mosi);
        if (mon_in < int'(W)) slv_rx[m_lsb ? mon_in : int'(W) - 1 - mon_in] = mosi;
        mon_in++;
      end else begin
        if (mon_out < int'(W)) slv_miso = wbit(slv_tx, mon_out, m_lsb);
        mon_out++;
      end
    end
    if (busy && (ss_n !== m_ss_exp)) mon_ss_err++;
    mon_busy = busy;
  end

  task automatic setup(input logic [1:0] md, input logic lsb, input logic [DIVW-1:0] dv,
                       input logic [SELW-1:0] sl, input logic [W-1:0] wd, input logic [W-1:0] sw,
                       input logic lp);
    m_cpol = md[1]; m_cpha = md[0]; m_lsb = lsb; slv_tx = sw; loop_en = lp;
    m_ss_exp = ss_exp(sl); mon_ss_err = 0;
    mode = md; lsb_first = lsb; div = dv; sel = sl; mdat = wd;
  endtask

  task automatic run_frame(input logic [1:0] md, input logic lsb, input logic [DIVW-1:0] dv,
                           input logic [SELW-1:0] sl, input logic [W-1:0] wd, input logic [W-1:0] sw,
                           input logic lp, input int poke);
    @(negedge clk);
    setup(md, lsb, dv, sl, wd, sw, lp);
    start = 1'b1;
    r_done = -1; r_busy_poke = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      start = (cyc == poke);
      if (cyc == 1) begin r_ss1 = ss_n; r_sclk1 = sclk; r_busy1 = busy; end
      if (cyc == poke + 1) r_busy_poke = busy;
      if (done) begin r_done = cyc; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (ss_n !== 5'b11111) begin failures++; $display("FAIL reset_ss_n got=%b exp=11111", ss_n); end
    checks++; if (sdat !== 8'h00) begin failures++; $display("FAIL reset_sdat got=%h exp=00", sdat); end
    reset = 1'b0;
  endtask

  task automatic test_loopback_mode0();
    run_frame(2'd0, 1'b0, 8'd0, 3'd0, 8'hA5, 8'h00, 1'b1, -10);
    checks++; if (sdat !== 8'hA5) begin failures++; $display("FAIL loop_sdat got=%h exp=a5", sdat); end
    checks++; if (r_done !== 19) begin failures++; $display("FAIL loop_done_cycle got=%0d exp=19", r_done); end
    checks++; if (mon_edges !== 16) begin failures++; $display("FAIL loop_edges got=%0d exp=16", mon_edges); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL loop_sclk_idle got=%b exp=0", sclk); end
    checks++; if (r_busy1 !== 1'b1) begin failures++; $display("FAIL loop_busy_c1 got=%b exp=1", r_busy1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_busy_done got=%b exp=0", busy); end
  endtask

  task automatic test_mode3();
    run_frame(2'd3, 1'b0, 8'd0, 3'd1, 8'hC3, 8'h3C, 1'b0, -10);
    checks++; if (sdat !== 8'h3C) begin failures++; $display("FAIL m3_sdat got=%h exp=3c", sdat); end
    checks++; if (slv_rx !== 8'hC3) begin failures++; $display("FAIL m3_slave_rx got=%h exp=c3", slv_rx); end
    checks++; if (sclk !== 1'b1) begin failures++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
    checks++; if (r_sclk1 !== 1'b1) begin failures++; $display("FAIL m3_sclk_c1 got=%b exp=1", r_sclk1); end
    checks++; if (mon_edges !== 16) begin failures++; $display("FAIL m3_edges got=%0d exp=16", mon_edges); end
  endtask

  task automatic test_lsb_mode1();
    logic [W-1:0] sw;
    sw = W'($urandom);
    run_frame(2'd1, 1'b1, 8'd0, 3'd0, 8'h01, sw, 1'b0, -10);
    checks++; if (slv_bits.size() !== 8) begin failures++; $display("FAIL lsb_bitcount got=%0d exp=8", slv_bits.size()); end
    for (int i = 0; i < 8 && i < slv_bits.size(); i++) begin
      checks++;
      if (slv_bits[i] !== (i == 0)) begin
        failures++; $display("FAIL lsb_mosi_bit%0d got=%b exp=%b", i, slv_bits[i], (i == 0));
      end
    end
    checks++; if (sdat !== sw) begin failures++; $display("FAIL lsb_sdat got=%h exp=%h", sdat, sw); end
  endtask

  task automatic test_div3_ignored();
    run_frame(2'd0, 1'b0, 8'd3, 3'd0, 8'h6E, 8'h00, 1'b1, 10);
    checks++; if (r_done !== 73) begin failures++; $display("FAIL div3_done_cycle got=%0d exp=73", r_done); end
    checks++; if (gap_min !== 4 || gap_max !== 4) begin
      failures++; $display("FAIL div3_half_period got=%0d..%0d exp=4", gap_min, gap_max);
    end
    checks++; if (r_busy_poke !== 1'b1) begin failures++; $display("FAIL div3_busy_after_poke got=%b exp=1", r_busy_poke); end
    checks++; if (sdat !== 8'h6E) begin failures++; $display("FAIL div3_sdat got=%h exp=6e", sdat); end
    begin
      int busy_cycles = 0;
      repeat (80) begin @(negedge clk); if (busy !== 1'b0) busy_cycles++; end
      checks++; if (busy_cycles !== 0) begin failures++; $display("FAIL div3_no_second_frame got=%0d busy cycles exp=0", busy_cycles); end
    end
  endtask

  task automatic test_select();
    run_frame(2'd2, 1'b0, 8'd1, 3'd2, 8'h11, 8'h99, 1'b0, -10);
    checks++; if (r_ss1 !== 5'b11011) begin failures++; $display("FAIL sel2_ss_n got=%b exp=11011", r_ss1); end
    checks++; if (mon_ss_err !== 0) begin failures++; $display("FAIL sel2_ss_hold got=%0d bad cycles exp=0", mon_ss_err); end
    checks++; if (ss_n !== 5'b11111) begin failures++; $display("FAIL sel2_ss_after got=%b exp=11111", ss_n); end
    run_frame(2'd0, 1'b0, 8'd0, 3'd5, 8'h22, 8'h77, 1'b0, -10);
    checks++; if (r_ss1 !== 5'b11111) begin failures++; $display("FAIL sel5_ss_n got=%b exp=11111", r_ss1); end
    checks++; if (r_done !== 19) begin failures++; $display("FAIL sel5_done got=%0d exp=19", r_done); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    setup(2'd0, 1'b0, 8'd1, 3'd0, 8'h3A, 8'h00, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (ss_n !== 5'b11111) begin failures++; $display("FAIL rstmid_ss_n got=%b exp=11111", ss_n); end
    checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rstmid_sclk got=%b exp=0", sclk); end
    if (done) dones++;
    repeat (60) begin @(negedge clk); if (done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, hi = 0;
    logic [W-1:0] s1 = '0, s2 = '0;
    @(negedge clk);
    setup(2'd0, 1'b0, 8'd0, 3'd0, 8'h5A, 8'h00, 1'b1);
    start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) mdat = 8'h96;
      if (done) begin
        if (d1 < 0) begin d1 = cyc; s1 = sdat; end
        else begin d2 = cyc; s2 = sdat; break; end
      end
      if (d1 >= 0 && ss_n[0]) hi++;
    end
    start = 1'b0;
    checks++; if (d1 !== 19) begin failures++; $display("FAIL b2b_done1 got=%0d exp=19", d1); end
    checks++; if (d2 !== 38) begin failures++; $display("FAIL b2b_done2 got=%0d exp=38", d2); end
    checks++; if (hi !== 1) begin failures++; $display("FAIL b2b_ss_gap got=%0d exp=1", hi); end
    checks++; if (s1 !== 8'h5A) begin failures++; $display("FAIL b2b_sdat1 got=%h exp=5a", s1); end
    checks++; if (s2 !== 8'h96) begin failures++; $display("FAIL b2b_sdat2 got=%h exp=96", s2); end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [1:0] md;  logic lsb, lp;  logic [DIVW-1:0] dv;  logic [SELW-1:0] sl;
      logic [W-1:0] wd, sw, exp_sdat;
      md = 2'($urandom_range(0, 3)); lsb = 1'($urandom_range(0, 1)); lp = 1'($urandom_range(0, 1));
      dv = DIVW'($urandom_range(0, 3)); sl = SELW'($urandom_range(0, 7));
      wd = W'($urandom); sw = W'($urandom);
      exp_sdat = lp ? wd : sw;
      run_frame(md, lsb, dv, sl, wd, sw, lp, -10);
      checks++; if (sdat !== exp_sdat) begin failures++; $display("FAIL rnd%0d_sdat got=%h exp=%h", n, sdat, exp_sdat); end
      checks++; if (slv_rx !== wd) begin failures++; $display("FAIL rnd%0d_slave_rx got=%h exp=%h", n, slv_rx, wd); end
      checks++; if (r_done !== done_at(dv)) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=%0d", n, r_done, done_at(dv)); end
      checks++; if (mon_edges !== 16) begin failures++; $display("FAIL rnd%0d_edges got=%0d exp=16", n, mon_edges); end
      checks++; if (r_ss1 !== ss_exp(sl)) begin failures++; $display("FAIL rnd%0d_ss_n got=%b exp=%b", n, r_ss1, ss_exp(sl)); end
      checks++; if (mon_ss_err !== 0) begin failures++; $display("FAIL rnd%0d_ss_hold got=%0d exp=0", n, mon_ss_err); end
      checks++; if (sclk !== md[1] || r_sclk1 !== md[1]) begin
        failures++; $display("FAIL rnd%0d_sclk_idle got=%b/%b exp=%b", n, r_sclk1, sclk, md[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback_mode0();
    test_mode3();
    test_lsb_mode1();
    test_div3_ignored();
    test_select();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
